tdc_capture_avg: RTL and testbench
==================================

// Module: tdc_capture_avg
// PURPOSE
// - Downstream consumer of the TDC delay-line sensor: samples the N_TAPS-wide tap vector each clk.
// - Converts thermometer code to a binary delay count, averages 2**ACC_LOG2 samples per measurement.
// - Presents the result on a valid/ready handshake for the readout logic driving uo_out.
// - Flags bubble (non-monotonic) codes caused by metastability or glitches.
// PARAMETERS
// - N_TAPS   16  taps sampled from the delay chain; tap 0 is closest to the chain input
// - ACC_LOG2 4   log2 of the samples averaged per measurement (1..8)
// - OUT_W    8   result width; must be >= $clog2(N_TAPS+1)
// PORTS
// - clk          in   1       system clock; the only clock
// - rst          in   1       synchronous, active-high reset
// - taps_in      in   N_TAPS  raw tap vector from the delay line, asynchronous to clk
// - start        in   1       one-cycle pulse: begin a measurement
// - busy         out  1       high from accepted start until result handshake completes
// - result       out  OUT_W   averaged delay count, zero-extended
// - result_valid out  1       result is available
// - result_ready in   1       consumer accepts result when valid && ready
// - last_count   out  CW      count of the most recent sample; CW = $clog2(N_TAPS+1)
// - bubble_err   out  1       sticky: a bubble was seen during the current or last measurement
// BEHAVIOUR
// - Reset (rst high at a clk edge): state IDLE; all outputs 0; synchronizer and accumulator 0.
// - Reset mid-measurement aborts it; no partial result is ever presented.
// - Synchronizer: 2 flops per tap; sample k is valid 2 cycles after taps_in is presented.
// - Thermo->bin: count = index of the lowest 0 tap, so the number of contiguous 1s from tap 0.
//   - All ones -> N_TAPS; all zeros -> 0.
//   - Any 1 above the first 0 is a bubble: count still = contiguous 1s, bubble_err set.
// - FSM:
//   - IDLE:  start -> FLUSH. Clear accumulator, sample counter and bubble_err. busy=1.
//   - FLUSH: 2 cycles, discards stale synchronizer contents -> ACCUM.
//   - ACCUM: each cycle sum += count and last_count <= count.
//     - After exactly 2**ACC_LOG2 samples -> HOLD.
//     - result <= sum >> ACC_LOG2, truncated, never rounded. result_valid=1.
//   - HOLD: result, result_valid and bubble_err stay stable while result_ready=0.
//     - valid && ready: result_valid=0, busy=0 -> IDLE.
//     - If start is high in the same cycle -> FLUSH directly.
// - Sum width: CW+ACC_LOG2; must not overflow (max N_TAPS*2**ACC_LOG2).
// - Sample counter: ACC_LOG2+1 bits; no wrap inside a measurement.
// - start while busy, outside the HOLD+ready cycle: ignored, no effect.
// - Latency, start to result_valid: 1 + 2 + 2**ACC_LOG2 cycles (19 at defaults).
// - bubble_err: cleared only on an accepted start or reset; holds through IDLE.
// - result_ready in IDLE, FLUSH or ACCUM: ignored.
// STRUCTURE
// - Shared package tdc_pkg:
//   - state enum {IDLE, FLUSH, ACCUM, HOLD}
//   - constants for CW and sum width, N_TAPS default
// - Sub-module tdc_therm2bin (combinational): tap vector -> count + bubble flag.
//   - Reused by later TDC variants.
// - Synchronizer flops marked keep / dont_touch; no logic between the two stages.
// TESTING
// - Reset: assert rst mid-ACCUM -> next cycle busy=0, result_valid=0, result=0, bubble_err=0.
// - Static taps 16'h00FF, start pulse -> result_valid at cycle 19, result=8, last_count=8.
// - Edge codes: taps 16'hFFFF -> result 16; taps 16'h0000 -> result 0; bubble_err=0 for both.
// - Bubble: taps 16'h0F0F constant -> result=4, bubble_err=1.
//   - bubble_err stays 1 after the handshake, clears on the next start.
// - Averaging: alternate 16'h001F (5) and 16'h003F (6) each cycle.
//   - sum=88 -> result=5 (truncation check).
// - Handshake: hold result_ready=0 for 10 cycles -> result stable, start ignored.
//   - ready and start high together -> valid drops, busy stays 1, new result 19 cycles later.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC capture family: default sizes, FSM encoding and width helpers.
package tdc_pkg;

  localparam int unsigned NTapsDefault   = 16;
  localparam int unsigned AccLog2Default = 4;
  localparam int unsigned OutWDefault    = 8;

  // Measurement FSM encoding
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFlush = 2'd1;
  localparam logic [1:0] StAccum = 2'd2;
  localparam logic [1:0] StHold  = 2'd3;

  // Bits needed to hold a count of 0..n_taps contiguous ones
  function automatic int unsigned count_width(input int unsigned n_taps);
    return $clog2(n_taps + 1);
  endfunction

  // Accumulator width: worst case n_taps * 2**acc_log2 must fit
  function automatic int unsigned sum_width(input int unsigned n_taps,
                                            input int unsigned acc_log2);
    return count_width(n_taps) + acc_log2;
  endfunction

endpackage

// File: rtl/tdc_therm2bin.sv
// Thermometer-to-binary converter for a TDC tap vector (purely combinational).
// count is the number of contiguous ones starting at tap 0; any one above the
// first zero is reported as a bubble.
module tdc_therm2bin
  import tdc_pkg::*;
#(
  parameter int unsigned N_TAPS = NTapsDefault,
  parameter int unsigned CW     = count_width(NTapsDefault)
) (
  input  logic [N_TAPS-1:0] taps,
  output logic [CW-1:0]     count,
  output logic              bubble
);

  logic seen_zero;

  // Scan upward from tap 0: count the ones until the first zero, flag any one after it
  always_comb begin
    seen_zero = 1'b0;
    count     = '0;
    bubble    = 1'b0;
    for (int unsigned i = 0; i < N_TAPS; i++) begin
      if (!seen_zero) begin
        if (taps[i]) begin
          count = CW'(i + 1);
        end else begin
          seen_zero = 1'b1;
        end
      end else if (taps[i]) begin
        bubble = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdc_capture_avg.sv
// TDC capture front end: synchronises the tap vector, converts it to a delay
// count and averages 2**ACC_LOG2 consecutive samples per measurement. The
// result is offered on a valid/ready handshake; bubble codes set a sticky flag.
module tdc_capture_avg
  import tdc_pkg::*;
#(
  parameter int unsigned N_TAPS   = NTapsDefault,
  parameter int unsigned ACC_LOG2 = AccLog2Default,
  parameter int unsigned OUT_W    = OutWDefault
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_TAPS-1:0]              taps_in,
  input  logic                           start,
  output logic                           busy,
  output logic [OUT_W-1:0]               result,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic [count_width(N_TAPS)-1:0] last_count,
  output logic                           bubble_err
);

  localparam int unsigned CW   = count_width(N_TAPS);
  localparam int unsigned SW   = sum_width(N_TAPS, ACC_LOG2);
  localparam int unsigned CntW = ACC_LOG2 + 1;

  localparam logic [CntW-1:0] CntOne       = CntW'(1);
  localparam logic [CntW-1:0] CntFlushLast = CntW'(1);
  localparam logic [CntW-1:0] CntAccLast   = CntW'((2 ** ACC_LOG2) - 1);

  // Two-stage synchroniser; nothing may be placed between the stages
  (* keep = "true", dont_touch = "true" *) logic [N_TAPS-1:0] sync1_q;
  (* keep = "true", dont_touch = "true" *) logic [N_TAPS-1:0] sync2_q;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SW-1:0]   sum_q, sum_d, sum_next;
  logic [OUT_W-1:0] result_q, result_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            bubble_q, bubble_d;
  logic [CW-1:0]   last_q, last_d;

  logic [CW-1:0]   count;
  logic            bubble;

  tdc_therm2bin #(
    .N_TAPS (N_TAPS),
    .CW     (CW)
  ) u_therm2bin (
    .taps   (sync2_q),
    .count  (count),
    .bubble (bubble)
  );

  // Measurement sequencing: IDLE -> FLUSH (2) -> ACCUM (2**ACC_LOG2) -> HOLD
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    result_d = result_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    bubble_d = bubble_q;
    last_d   = last_q;
    sum_next = sum_q + SW'(count);
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StFlush;
          cnt_d    = '0;
          sum_d    = '0;
          bubble_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      StFlush: begin
        // Synchroniser still holds pre-start taps; drop them
        if (cnt_q == CntFlushLast) begin
          state_d = StAccum;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StAccum: begin
        sum_d  = sum_next;
        last_d = count;
        cnt_d  = cnt_q + CntOne;
        if (bubble) begin
          bubble_d = 1'b1;
        end
        if (cnt_q == CntAccLast) begin
          state_d  = StHold;
          result_d = OUT_W'(sum_next >> ACC_LOG2);
          valid_d  = 1'b1;
        end
      end
      StHold: begin
        if (result_ready) begin
          valid_d = 1'b0;
          if (start) begin
            // Back-to-back: restart without passing through IDLE
            state_d  = StFlush;
            cnt_d    = '0;
            sum_d    = '0;
            bubble_d = 1'b0;
          end else begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Synchroniser flops
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= taps_in;
      sync2_q <= sync1_q;
    end
  end

  // Control and datapath state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sum_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      bubble_q <= 1'b0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      bubble_q <= bubble_d;
      last_q   <= last_d;
    end
  end

  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign last_count   = last_q;
  assign bubble_err   = bubble_q;

endmodule

// File: tb/tb_tdc_capture_avg.sv
// Self-checking bench for tdc_capture_avg at default parameters (16 taps, 16-sample average).
module tb_tdc_capture_avg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] taps_in;
  logic        start;
  logic        busy;
  logic [7:0]  result;
  logic        result_valid;
  logic        result_ready;
  logic [4:0]  last_count;
  logic        bubble_err;

  int checks   = 0;
  int failures = 0;

  // Per-cycle stimulus for one measurement; index 0 is the cycle start is high
  logic [15:0] stim       [0:40];
  logic        stim_start [0:40];
  logic        stim_ready [0:40];

  int   lat;
  logic busy_e0;
  int   exp_res;
  int   exp_last;
  bit   exp_bub;

  tdc_capture_avg dut (
    .clk          (clk),
    .rst          (rst),
    .taps_in      (taps_in),
    .start        (start),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .last_count   (last_count),
    .bubble_err   (bubble_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: length of the run of ones starting at tap 0
  function automatic int ref_count(input logic [15:0] t);
    int c = 0;
    while (c < 16 && t[c] == 1'b1) c++;
    return c;
  endfunction

  function automatic bit ref_bubble(input logic [15:0] t);
    return (t >> ref_count(t)) != 16'h0;
  endfunction

  // Taps presented in cycles 1..16 after start are the ones averaged
  task automatic model_expect();
    int sum = 0;
    exp_bub = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      sum += ref_count(stim[j]);
      if (ref_bubble(stim[j])) exp_bub = 1'b1;
    end
    exp_res  = sum / 16;
    exp_last = ref_count(stim[16]);
  endtask

  task automatic fill_const(input logic [15:0] v);
    for (int j = 0; j <= 40; j++) begin
      stim[j]       = v;
      stim_start[j] = 1'b0;
      stim_ready[j] = 1'b0;
    end
  endtask

  // Pulse start, play the stimulus and stop at result_valid (bounded)
  task automatic drive_meas(input logic rdy0);
    lat          = 0;
    start        = 1'b1;
    result_ready = rdy0;
    taps_in      = stim[0];
    for (int j = 0; j < 40; j++) begin
      tick();
      if (j == 0) busy_e0 = busy;
      if (result_valid) begin
        start        = 1'b0;
        result_ready = 1'b0;
        lat          = j + 1;
        break;
      end
      start        = stim_start[j + 1];
      result_ready = stim_ready[j + 1];
      taps_in      = stim[j + 1];
    end
    start        = 1'b0;
    result_ready = 1'b0;
  endtask

  task automatic accept();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    int seen_valid;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, result_valid, result, last_count, bubble_err} !== 16'h0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b valid=%b result=%0d last=%0d bub=%b, want all 0",
               busy, result_valid, result, last_count, bubble_err);
    end
    // Leave a nonzero result and sticky bubble behind, then abort a measurement
    fill_const(16'h0F0F);
    drive_meas(1'b0);
    accept();
    fill_const(16'h00FF);
    start   = 1'b1;
    taps_in = 16'h00FF;
    tick();
    start = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, result_valid, result, last_count, bubble_err} !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid_accum: got busy=%b valid=%b result=%0d last=%0d bub=%b, want 0",
               busy, result_valid, result, last_count, bubble_err);
    end
    seen_valid = 0;
    repeat (25) begin
      tick();
      if (result_valid) seen_valid++;
    end
    checks++;
    if (seen_valid != 0) begin
      failures++;
      $display("FAIL reset_no_partial: valid seen %0d cycles, want 0", seen_valid);
    end
  endtask

  task automatic test_static();
    fill_const(16'h00FF);
    drive_meas(1'b0);
    checks++;
    if (lat != 19) begin
      failures++;
      $display("FAIL static_latency: got %0d, want 19", lat);
    end
    checks++;
    if (result !== 8'd8 || last_count !== 5'd8 || bubble_err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL static_00ff: result=%0d last=%0d bub=%b busy=%b, want 8 8 0 1",
               result, last_count, bubble_err, busy);
    end
    accept();
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL static_handshake: valid=%b busy=%b, want 0 0", result_valid, busy);
    end
  endtask

  task automatic test_edges();
    logic [15:0] pats [0:1];
    int          want [0:1];
    pats[0] = 16'hFFFF; want[0] = 16;
    pats[1] = 16'h0000; want[1] = 0;
    for (int k = 0; k < 2; k++) begin
      fill_const(pats[k]);
      drive_meas(1'b0);
      checks++;
      if (lat != 19 || int'(result) != want[k] || int'(last_count) != want[k] ||
          bubble_err !== 1'b0) begin
        failures++;
        $display("FAIL edge_%h: lat=%0d result=%0d last=%0d bub=%b, want 19 %0d %0d 0",
                 pats[k], lat, result, last_count, bubble_err, want[k], want[k]);
      end
      accept();
    end
  endtask

  task automatic test_bubble();
    int waited;
    fill_const(16'h0F0F);
    drive_meas(1'b0);
    checks++;
    if (result !== 8'd4 || bubble_err !== 1'b1) begin
      failures++;
      $display("FAIL bubble_result: result=%0d bub=%b, want 4 1", result, bubble_err);
    end
    accept();
    repeat (3) tick();
    checks++;
    if (bubble_err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bubble_sticky: bub=%b busy=%b, want 1 0", bubble_err, busy);
    end
    taps_in = 16'h00FF;
    start   = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (bubble_err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL bubble_clear_on_start: bub=%b busy=%b, want 0 1", bubble_err, busy);
    end
    waited = 0;
    while (!result_valid && waited < 40) begin
      tick();
      waited++;
    end
    checks++;
    if (!result_valid || result !== 8'd8 || bubble_err !== 1'b0) begin
      failures++;
      $display("FAIL bubble_followup: valid=%b result=%0d bub=%b, want 1 8 0",
               result_valid, result, bubble_err);
    end
    accept();
  endtask

  task automatic test_averaging();
    fill_const(16'h001F);
    for (int j = 0; j <= 40; j++) stim[j] = (j % 2 == 0) ? 16'h001F : 16'h003F;
    model_expect();
    drive_meas(1'b0);
    checks++;
    if (lat != 19 || result !== 8'd5 || int'(last_count) != exp_last) begin
      failures++;
      $display("FAIL averaging_trunc: lat=%0d result=%0d last=%0d, want 19 5 %0d",
               lat, result, last_count, exp_last);
    end
    accept();
  endtask

  task automatic test_handshake();
    int unstable;
    fill_const(16'h07FF);
    drive_meas(1'b0);
    unstable = 0;
    for (int c = 0; c < 10; c++) begin
      start   = (c == 3);
      taps_in = 16'hFFFF;
      tick();
      if (result_valid !== 1'b1 || result !== 8'd11 || busy !== 1'b1) unstable++;
    end
    start = 1'b0;
    checks++;
    if (unstable != 0) begin
      failures++;
      $display("FAIL hold_stable: %0d cycles changed, want 0 (result=%0d valid=%b)",
               unstable, result, result_valid);
    end
    fill_const(16'h0003);
    drive_meas(1'b1);
    checks++;
    if (busy_e0 !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back_busy: busy=%b after ready+start, want 1", busy_e0);
    end
    checks++;
    if (lat != 19 || result !== 8'd2) begin
      failures++;
      $display("FAIL back_to_back_result: lat=%0d result=%0d, want 19 2", lat, result);
    end
    accept();
  endtask

  task automatic test_random();
    int mode;
    int k;
    int unstable;
    logic [15:0] t;
    for (int m = 0; m < 8; m++) begin
      fill_const(16'h0);
      for (int j = 0; j <= 40; j++) begin
        mode = $urandom_range(0, 3);
        k    = $urandom_range(0, 16);
        t    = 16'((32'd1 << k) - 32'd1);
        if (mode == 2) t = 16'($urandom);
        if (mode == 3) t[$urandom_range(0, 15)] = 1'b1;
        stim[j] = t;
      end
      // Spurious start/ready during FLUSH/ACCUM must be ignored
      for (int j = 1; j <= 15; j++) begin
        stim_start[j] = ($urandom_range(0, 4) == 0);
        stim_ready[j] = ($urandom_range(0, 3) == 0);
      end
      model_expect();
      drive_meas(1'b0);
      checks++;
      if (lat != 19 || int'(result) != exp_res || int'(last_count) != exp_last ||
          bubble_err !== exp_bub) begin
        failures++;
        $display("FAIL random_%0d: lat=%0d result=%0d last=%0d bub=%b, want 19 %0d %0d %b",
                 m, lat, result, last_count, bubble_err, exp_res, exp_last, exp_bub);
      end
      unstable = 0;
      repeat ($urandom_range(0, 3)) begin
        taps_in = 16'($urandom);
        tick();
        if (result_valid !== 1'b1 || int'(result) != exp_res) unstable++;
      end
      accept();
      checks++;
      if (unstable != 0 || result_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL random_hs_%0d: unstable=%0d valid=%b busy=%b, want 0 0 0",
                 m, unstable, result_valid, busy);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    taps_in      = 16'h0;
    start        = 1'b0;
    result_ready = 1'b0;
    test_reset();
    test_static();
    test_edges();
    test_bubble();
    test_averaging();
    test_handshake();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
